// File: rtl/accel_seq_pkg.sv
// Shared types and constants for the accelerometer sweep sequencer.
// Holds FSM/axis enums, datapath widths and the per-axis address map.
package accel_seq_pkg;

  localparam int SAMPLE_W   = 10;
  localparam int VALUE_W    = 12;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_SPI,
    CONVERT,
    PUBLISH
  } state_e;

  typedef enum logic [1:0] {
    AXIS_X,
    AXIS_Y,
    AXIS_Z
  } axis_e;

  localparam logic [7:0] AXIS_OFS_X = 8'd0;
  localparam logic [7:0] AXIS_OFS_Y = 8'd2;
  localparam logic [7:0] AXIS_OFS_Z = 8'd4;

  function automatic logic [7:0] axis_offset(axis_e a);
    unique case (a)
      AXIS_X:  return AXIS_OFS_X;
      AXIS_Y:  return AXIS_OFS_Y;
      AXIS_Z:  return AXIS_OFS_Z;
      default: return AXIS_OFS_X;
    endcase
  endfunction

  function automatic axis_e axis_next(axis_e a);
    unique case (a)
      AXIS_X:  return AXIS_Y;
      AXIS_Y:  return AXIS_Z;
      default: return AXIS_X;
    endcase
  endfunction

endpackage

// File: rtl/accel_axis_sequencer_if.sv
// SPI request/response handshake plus the published result bus.
// master = sequencer side, slave = SPI master / display side.
interface accel_axis_sequencer_if;

  logic       spi_req;
  logic [7:0] spi_addr;
  logic       spi_done;
  logic [15:0] spi_rdata;

  logic       out_valid;
  logic [1:0] out_axis;
  logic       out_neg;
  logic [3:0] out_thousands;
  logic [3:0] out_hundreds;
  logic [3:0] out_tens;
  logic [3:0] out_ones;

  modport master (
    output spi_req,
    output spi_addr,
    input  spi_done,
    input  spi_rdata,
    output out_valid,
    output out_axis,
    output out_neg,
    output out_thousands,
    output out_hundreds,
    output out_tens,
    output out_ones
  );

  modport slave (
    input  spi_req,
    input  spi_addr,
    output spi_done,
    output spi_rdata,
    input  out_valid,
    input  out_axis,
    input  out_neg,
    input  out_thousands,
    input  out_hundreds,
    input  out_tens,
    input  out_ones
  );

endinterface

// File: rtl/bcd_serial_converter.sv
// Serial double-dabble: 12-bit binary to 4 BCD digits, one bit per clock.
// The first iteration happens on the start edge, so done pulses 12 clocks later.
module bcd_serial_converter
  import accel_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [VALUE_W-1:0] value,
  output logic               done,
  output logic [3:0]         thousands,
  output logic [3:0]         hundreds,
  output logic [3:0]         tens,
  output logic [3:0]         ones
);

  localparam int W = BCD_W + VALUE_W;

  logic [W-1:0] acc_q;
  logic [3:0]   cnt_q;
  logic         done_q;

  function automatic logic [W-1:0] dd_step(input logic [W-1:0] v);
    logic [W-1:0] t;
    t = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (t[VALUE_W+4*i +: 4] >= 4'd5)
        t[VALUE_W+4*i +: 4] = t[VALUE_W+4*i +: 4] + 4'd3;
    end
    return {t[W-2:0], 1'b0};
  endfunction

  // shift/add-3 engine; cnt_q holds the iterations still to run
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (start) begin
      acc_q  <= dd_step({{BCD_W{1'b0}}, value});
      cnt_q  <= 4'(VALUE_W - 1);
      done_q <= 1'b0;
    end else if (cnt_q != 4'd0) begin
      acc_q  <= dd_step(acc_q);
      cnt_q  <= cnt_q - 4'd1;
      done_q <= (cnt_q == 4'd1);
    end else begin
      done_q <= 1'b0;
    end
  end

  assign done      = done_q;
  assign thousands = acc_q[W-1 -: 4];
  assign hundreds  = acc_q[W-5 -: 4];
  assign tens      = acc_q[W-9 -: 4];
  assign ones      = acc_q[W-13 -: 4];

endmodule

// File: rtl/accel_axis_sequencer.sv
// Periodic X/Y/Z accelerometer sweep: SPI read, sign/magnitude, BCD, publish.
// One result per axis; SPI timeouts skip the axis and latch timeout_err.
module accel_axis_sequencer
  import accel_seq_pkg::*;
#(
  parameter int unsigned INTERVAL_CYCLES = 100000,
  parameter int unsigned SPI_TIMEOUT     = 4096,
  parameter logic [7:0]  AXIS_BASE_ADDR  = 8'h32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  accel_axis_sequencer_if.master bus,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int IW = $clog2(INTERVAL_CYCLES + 1);
  localparam int TW = $clog2(SPI_TIMEOUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(INTERVAL_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST = TW'(SPI_TIMEOUT - 1);

  state_e state_q;
  state_e state_d;
  axis_e  axis_q;

  logic [IW-1:0] icnt_q;
  logic [TW-1:0] tcnt_q;
  logic          neg_q;
  logic          tmo_q;

  logic [1:0] out_axis_q;
  logic       out_neg_q;
  logic [3:0] out_th_q;
  logic [3:0] out_hu_q;
  logic [3:0] out_te_q;
  logic [3:0] out_on_q;

  logic [SAMPLE_W-1:0] sample;
  logic [SAMPLE_W-1:0] mag;
  logic [VALUE_W-1:0]  value;
  logic                sample_neg;
  logic                rdata_unused;

  logic conv_start;
  logic conv_done;
  logic [3:0] cv_th;
  logic [3:0] cv_hu;
  logic [3:0] cv_te;
  logic [3:0] cv_on;

  logic ivl_hit;
  logic sweep_start;
  logic sweep_end;
  logic t_expire;
  logic axis_adv;

  logic       spi_req;
  logic [7:0] spi_addr;
  logic       out_valid;

  // The 10-bit sample is split across both bytes; -512 maps to magnitude 512.
  assign sample       = {bus.spi_rdata[6:0], bus.spi_rdata[15:13]};
  assign sample_neg   = sample[SAMPLE_W-1];
  assign mag          = sample_neg ? (~sample + SAMPLE_W'(1)) : sample;
  assign value        = {mag, 2'b00};
  assign rdata_unused = ^bus.spi_rdata[12:7];

  assign ivl_hit     = (icnt_q == I_LAST);
  assign sweep_start = (state_q == IDLE) && enable && ivl_hit;
  assign sweep_end   = !enable || (axis_q == AXIS_Z);
  assign conv_start  = (state_q == WAIT_SPI) && bus.spi_done;
  assign t_expire    = (state_q == WAIT_SPI) && !bus.spi_done
                       && (tcnt_q == T_LAST);
  assign axis_adv    = (state_q == PUBLISH) || t_expire;

  bcd_serial_converter u_bcd (
    .clk       (clk),
    .rst       (rst),
    .start     (conv_start),
    .value     (value),
    .done      (conv_done),
    .thousands (cv_th),
    .hundreds  (cv_hu),
    .tens      (cv_te),
    .ones      (cv_on)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; spi_done beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (sweep_start) state_d = REQ;
      REQ:      state_d = WAIT_SPI;
      WAIT_SPI: begin
        if (bus.spi_done)  state_d = CONVERT;
        else if (t_expire) state_d = sweep_end ? IDLE : REQ;
      end
      CONVERT:  if (conv_done) state_d = PUBLISH;
      PUBLISH:  state_d = sweep_end ? IDLE : REQ;
      default:  state_d = IDLE;
    endcase
  end

  // output decode from state
  always_comb begin
    spi_req   = 1'b0;
    spi_addr  = '0;
    out_valid = 1'b0;
    busy      = (state_q != IDLE);
    unique case (state_q)
      REQ, WAIT_SPI: begin
        spi_req  = 1'b1;
        spi_addr = AXIS_BASE_ADDR + axis_offset(axis_q);
      end
      PUBLISH: out_valid = 1'b1;
      default: ;
    endcase
  end

  // interval counter: restarts on sweep start, saturates once expired
  always_ff @(posedge clk) begin
    if (rst)              icnt_q <= '0;
    else if (sweep_start) icnt_q <= '0;
    else if (!ivl_hit)    icnt_q <= icnt_q + IW'(1);
  end

  // SPI wait timer, only runs in WAIT_SPI
  always_ff @(posedge clk) begin
    if (rst)                       tcnt_q <= '0;
    else if (state_q == WAIT_SPI)  tcnt_q <= tcnt_q + TW'(1);
    else                           tcnt_q <= '0;
  end

  // axis pointer; back to X at the end of a sweep or when disabled
  always_ff @(posedge clk) begin
    if (rst)           axis_q <= AXIS_X;
    else if (axis_adv) axis_q <= sweep_end ? AXIS_X : axis_next(axis_q);
  end

  // sticky timeout flag and sign captured with the SPI data
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= 1'b0;
      neg_q <= 1'b0;
    end else begin
      if (t_expire)   tmo_q <= 1'b1;
      if (conv_start) neg_q <= sample_neg;
    end
  end

  // result registers load as the conversion finishes, held until next result
  always_ff @(posedge clk) begin
    if (rst) begin
      out_axis_q <= '0;
      out_neg_q  <= 1'b0;
      out_th_q   <= '0;
      out_hu_q   <= '0;
      out_te_q   <= '0;
      out_on_q   <= '0;
    end else if ((state_q == CONVERT) && conv_done) begin
      out_axis_q <= axis_q;
      out_neg_q  <= neg_q;
      out_th_q   <= cv_th;
      out_hu_q   <= cv_hu;
      out_te_q   <= cv_te;
      out_on_q   <= cv_on;
    end
  end

  assign timeout_err       = tmo_q;
  assign bus.spi_req       = spi_req;
  assign bus.spi_addr      = spi_addr;
  assign bus.out_valid     = out_valid;
  assign bus.out_axis      = out_axis_q;
  assign bus.out_neg       = out_neg_q;
  assign bus.out_thousands = out_th_q;
  assign bus.out_hundreds  = out_hu_q;
  assign bus.out_tens      = out_te_q;
  assign bus.out_ones      = out_on_q;

endmodule

// File: tb/tb_accel_axis_sequencer.sv
// Directed/randomized bench for accel_axis_sequencer.
// Expected results come from an arithmetic model of the sample format.
module tb_accel_axis_sequencer;

  localparam int         INTERVAL = 20;
  localparam int         TMO      = 16;
  localparam logic [7:0] BASE     = 8'h32;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic busy;
  logic timeout_err;

  int checks = 0;
  int errors = 0;

  accel_axis_sequencer_if bus();

  accel_axis_sequencer #(
    .INTERVAL_CYCLES (INTERVAL),
    .SPI_TIMEOUT     (TMO),
    .AXIS_BASE_ADDR  (BASE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] rd, output logic neg,
                                output logic [15:0] dig);
    int s;
    int v;
    s = int'({rd[6:0], rd[15:13]});
    if (s >= 512) s = s - 1024;
    neg = (s < 0);
    v = (s < 0 ? -s : s) * 4;
    dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic serve(input int ax, input logic [15:0] rd, input int d,
                       input bit drop_en, output int waited);
    int n;
    bit held;
    logic exp_neg;
    logic [15:0] exp_dig;
    model(rd, exp_neg, exp_dig);
    n = 0;
    while (!bus.spi_req && n < 200) begin
      tick();
      n++;
    end
    waited = n;
    check("spi_req_rise", 32'(bus.spi_req), 32'd1);
    check("spi_addr", 32'(bus.spi_addr), 32'(BASE) + 32'(2 * ax));
    check("busy_req", 32'(busy), 32'd1);
    held = 1'b1;
    for (int i = 0; i < d; i++) begin
      tick();
      if (drop_en && i == 0) enable = 1'b0;
      if (!bus.spi_req || bus.spi_addr != BASE + 8'(2 * ax)) held = 1'b0;
    end
    check("spi_req_held", 32'(held), 32'd1);
    bus.spi_done  = 1'b1;
    bus.spi_rdata = rd;
    tick();
    bus.spi_done  = 1'b0;
    bus.spi_rdata = 16'($urandom);
    check("spi_req_drop", 32'(bus.spi_req), 32'd0);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check("latency", 32'(n), 32'd13);
    check("out_axis", 32'(bus.out_axis), 32'(ax));
    check("out_neg", 32'(bus.out_neg), 32'(exp_neg));
    check("digits", 32'({bus.out_thousands, bus.out_hundreds,
                         bus.out_tens, bus.out_ones}), 32'(exp_dig));
    tick();
    check("out_valid_pulse", 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int  w;
    int  n;
    bit  flag;
    rst           = 1'b1;
    enable        = 1'b0;
    bus.spi_done  = 1'b0;
    bus.spi_rdata = '0;
    repeat (3) tick();
    check("rst_spi_req", 32'(bus.spi_req), 32'd0);
    check("rst_spi_addr", 32'(bus.spi_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_axis", 32'(bus.out_axis), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_digits", 32'({bus.out_neg, bus.out_thousands, bus.out_hundreds,
                             bus.out_tens, bus.out_ones}), 32'd0);

    rst    = 1'b0;
    enable = 1'b1;
    n = 0;
    while (!bus.spi_req && n < 100) begin
      tick();
      n++;
    end
    check("first_sweep_start", 32'(n), 32'(INTERVAL));

    serve(0, 16'hE000, 1, 1'b0, w);
    serve(1, 16'hE07F, 3, 1'b0, w);
    check("y_back_to_back", 32'(w), 32'd0);
    serve(2, 16'h0040, 2, 1'b0, w);
    check("z_back_to_back", 32'(w), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_spi_req", 32'(bus.spi_req), 32'd0);

    serve(0, 16'hE03F, TMO, 1'b0, w);
    check("overrun_restart", 32'(w), 32'd1);
    check("done_beats_timeout", 32'(timeout_err), 32'd0);
    serve(1, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    serve(2, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);

    serve(0, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    check("tmo_y_req", 32'(bus.spi_addr), 32'(BASE) + 32'd2);
    n = 0;
    flag = 1'b0;
    while (bus.spi_req && bus.spi_addr == BASE + 8'd2 && n < 100) begin
      n++;
      tick();
      if (bus.out_valid) flag = 1'b1;
    end
    check("tmo_req_cycles", 32'(n), 32'(TMO + 1));
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_no_valid", 32'(flag), 32'd0);
    check("tmo_next_req", 32'(bus.spi_req), 32'd1);
    check("tmo_next_addr", 32'(bus.spi_addr), 32'(BASE) + 32'd4);
    serve(2, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    check("tmo_z_wait", 32'(w), 32'd0);

    serve(0, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    serve(1, 16'($urandom), 4, 1'b1, w);
    check("dis_busy", 32'(busy), 32'd0);
    check("dis_spi_req", 32'(bus.spi_req), 32'd0);
    flag = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.spi_done  = (i == 5);
      bus.spi_rdata = 16'hE03F;
      tick();
      if (bus.spi_req || busy || bus.out_valid) flag = 1'b1;
    end
    bus.spi_done = 1'b0;
    check("stay_idle", 32'(flag), 32'd0);
    check("sticky_err", 32'(timeout_err), 32'd1);
    enable = 1'b1;
    serve(0, 16'hE03F, 2, 1'b0, w);
    check("restart_from_x", 32'(w), 32'd1);

    n = 0;
    while (!bus.spi_req && n < 100) begin
      tick();
      n++;
    end
    check("rst_test_y_req", 32'(bus.spi_addr), 32'(BASE) + 32'd2);
    tick();
    tick();
    bus.spi_done  = 1'b1;
    bus.spi_rdata = 16'($urandom);
    tick();
    bus.spi_done = 1'b0;
    repeat (5) tick();
    check("mid_convert_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    check("mrst_spi_req", 32'(bus.spi_req), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_timeout", 32'(timeout_err), 32'd0);
    check("mrst_outs", 32'({bus.out_valid, bus.out_axis, bus.out_neg,
                            bus.out_thousands, bus.out_hundreds,
                            bus.out_tens, bus.out_ones}), 32'd0);
    rst = 1'b0;
    n = 0;
    while (!bus.spi_req && n < 100) begin
      tick();
      n++;
    end
    check("post_rst_start", 32'(n), 32'(INTERVAL));
    serve(0, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    serve(1, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);
    serve(2, 16'($urandom), int'($urandom_range(1, TMO)), 1'b0, w);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
